// File: rtl/aes_ctr_iter.sv
`default_nettype none
// ============================================================================
// aes_ctr_iter : iterative AES-128/256 CTR engine, one round per clock with
// on-the-fly key expansion.                                   Rev 1.0
// ============================================================================

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [10:0] sel;

  // Entry 0 sits in the top byte, so the bit offset is (255 - in) * 8.
  assign sel      = {~in_byte, 3'b000};
  assign out_byte = SBOX[sel +: 8];
endmodule

module aes_ctr_iter #(
  parameter int KEY_BITS = 256,
  parameter int CTR_BITS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  input  logic [127:0] iv,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic [31:0]  blk_cnt
);
  localparam int         NR         = (KEY_BITS == 128) ? 10 : 14;
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_ctr_iter: KEY_BITS must be 128 or 256");
    end
    if (CTR_BITS < 8 || CTR_BITS > 128) begin : g_bad_ctr
      $error("aes_ctr_iter: CTR_BITS must be in 8..128");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t              state, next_state;
  logic [KEY_BITS-1:0] shadow_key, wkey, next_wkey;
  logic [127:0]        ctr, ctr_inc, st, data_reg, rk, round_out;
  logic [127:0]        sb_vec, sr_vec, mc_vec, base;
  logic                last_reg, final_round, use_rot;
  logic                key_hs, s_hs, m_hs;
  logic [3:0]          round;
  logic [7:0]          rcon;
  logic [31:0]         sub_in, sub_out, temp, nw0, nw1, nw2, nw3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  assign key_hs = key_valid & key_ready;
  assign s_hs   = s_valid & s_ready;
  assign m_hs   = m_valid & m_ready;

  // Byte i of the state is row i%4, column i/4; ShiftRows pulls from column (c+r)%4.
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    localparam int ROW = i % 4;
    localparam int COL = i / 4;
    localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
    aes_sbox u_sbox (.in_byte(st[127-8*i -: 8]), .out_byte(sb_vec[127-8*i -: 8]));
    assign sr_vec[127-8*i -: 8] = sb_vec[127-8*SRC -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc_vec[127-32*c -: 32] = mix_col(sr_vec[127-32*c -: 32]);
  end

  for (genvar k = 0; k < 4; k++) begin : g_key_sbox
    aes_sbox u_sbox (.in_byte(sub_in[31-8*k -: 8]), .out_byte(sub_out[31-8*k -: 8]));
  end

  assign final_round = (round == LAST_ROUND);
  assign round_out   = (final_round ? sr_vec : mc_vec) ^ rk;

  assign base   = wkey[KEY_BITS-1 -: 128];
  assign sub_in = use_rot ? {wkey[23:0], wkey[31:24]} : wkey[31:0];
  assign temp   = use_rot ? (sub_out ^ {rcon, 24'h000000}) : sub_out;
  assign nw0    = base[127:96] ^ temp;
  assign nw1    = base[95:64]  ^ nw0;
  assign nw2    = base[63:32]  ^ nw1;
  assign nw3    = base[31:0]   ^ nw2;

  // AES-256 keeps an 8-word window; its second half is already the next round key.
  generate
    if (KEY_BITS == 128) begin : g_k128
      assign use_rot   = 1'b1;
      assign rk        = {nw0, nw1, nw2, nw3};
      assign next_wkey = {nw0, nw1, nw2, nw3};
    end else begin : g_k256
      assign use_rot   = round[0];
      assign rk        = wkey[127:0];
      assign next_wkey = {wkey[127:0], nw0, nw1, nw2, nw3};
    end

    if (CTR_BITS == 128) begin : g_ctr_full
      assign ctr_inc = ctr + 128'd1;
    end else begin : g_ctr_part
      assign ctr_inc = {ctr[127:CTR_BITS], ctr[CTR_BITS-1:0] + CTR_BITS'(1)};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    key_ready  = 1'b0;
    s_ready    = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) next_state = READY;
      end
      READY: begin
        key_ready = 1'b1;
        s_ready   = 1'b1;
        if (s_valid) next_state = ROUND;
      end
      ROUND: if (final_round) next_state = OUT;
      OUT:   if (m_ready) next_state = READY;
      default: next_state = IDLE;
    endcase
    if (rst) begin
      key_ready = 1'b0;
      s_ready   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_key <= '0;
      wkey       <= '0;
      ctr        <= '0;
      st         <= '0;
      data_reg   <= '0;
      last_reg   <= 1'b0;
      round      <= 4'd0;
      rcon       <= 8'h00;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      if (s_hs) begin
        st       <= ctr ^ shadow_key[KEY_BITS-1 -: 128];
        wkey     <= shadow_key;
        round    <= 4'd1;
        rcon     <= 8'h01;
        data_reg <= s_data;
        last_reg <= s_last;
        ctr      <= ctr_inc;
      end
      // Placed after the block start so a same-cycle key load overrides the increment.
      if (key_hs) begin
        shadow_key <= key[255 -: KEY_BITS];
        ctr        <= iv;
        blk_cnt    <= '0;
      end
      if (state == ROUND) begin
        st    <= round_out;
        wkey  <= next_wkey;
        round <= round + 4'd1;
        if (use_rot) rcon <= xtime(rcon);
        if (final_round) begin
          m_valid <= 1'b1;
          m_data  <= round_out ^ data_reg;
          m_last  <= last_reg;
        end
      end
      if (m_hs) begin
        m_valid <= 1'b0;
        blk_cnt <= blk_cnt + 32'd1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_aes_ctr_iter.sv
`default_nettype none
// ============================================================================
// tb_aes_ctr_iter : directed bench for aes_ctr_iter, AES-256/CTR32 and
// AES-128/CTR8 instances checked against FIPS-197 / SP800-38A vectors.  Rev 1.0
// ============================================================================
module tb_aes_ctr_iter;
  localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E256    = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128    = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [127:0] E128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KSP     = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h55aa55aa55aa55aa55aa55aa55aa55aa};
  localparam logic [127:0] CTR_SP  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] PT1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT1     = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] IV_WRAP = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdffff;
  localparam logic [127:0] PT2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT2     = 128'h9806f66b7970fdff8617187bb9fffdff;

  logic clk = 1'b0;
  logic rst;
  logic         key_valid [2];
  logic         key_ready [2];
  logic [255:0] key       [2];
  logic [127:0] iv        [2];
  logic         s_valid   [2];
  logic         s_ready   [2];
  logic [127:0] s_data    [2];
  logic         s_last    [2];
  logic         m_valid   [2];
  logic         m_ready   [2];
  logic [127:0] m_data    [2];
  logic         m_last    [2];
  logic [31:0]  blk_cnt   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_ctr_iter #(.KEY_BITS(256), .CTR_BITS(32)) dut256 (
    .clk(clk), .rst(rst),
    .key_valid(key_valid[0]), .key_ready(key_ready[0]), .key(key[0]), .iv(iv[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0]),
    .blk_cnt(blk_cnt[0])
  );

  aes_ctr_iter #(.KEY_BITS(128), .CTR_BITS(8)) dut128 (
    .clk(clk), .rst(rst),
    .key_valid(key_valid[1]), .key_ready(key_ready[1]), .key(key[1]), .iv(iv[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1]),
    .blk_cnt(blk_cnt[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic load_key(input int d, input logic [255:0] k, input logic [127:0] v, input string tag);
    int n = 0;
    key[d] = k;
    iv[d] = v;
    key_valid[d] = 1'b1;
    while (!key_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chkb({tag, ".key_ready"}, key_ready[d], 1'b1);
    @(negedge clk);
    key_valid[d] = 1'b0;
    chk({tag, ".blk_cnt_clr"}, 128'(blk_cnt[d]), 128'd0);
  endtask

  task automatic wait_out(input int d, input int nr, input logic chk_data, input logic [127:0] exp,
                          input logic last, input string tag);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_valid[d] && lat < 40);
    chk({tag, ".latency"}, 128'(lat), 128'(nr));
    if (chk_data) chk({tag, ".m_data"}, m_data[d], exp);
    chkb({tag, ".m_last"}, m_last[d], last);
  endtask

  task automatic run_block(input int d, input logic [127:0] data, input logic last, input int nr,
                           input logic chk_data, input logic [127:0] exp, input string tag);
    s_data[d] = data;
    s_last[d] = last;
    s_valid[d] = 1'b1;
    chkb({tag, ".s_ready"}, s_ready[d], 1'b1);
    @(negedge clk);
    s_valid[d] = 1'b0;
    wait_out(d, nr, chk_data, exp, last, tag);
  endtask

  task automatic release_out(input int d, input logic [31:0] cnt, input string tag);
    m_ready[d] = 1'b1;
    @(negedge clk);
    m_ready[d] = 1'b0;
    chkb({tag, ".m_valid_low"}, m_valid[d], 1'b0);
    chkb({tag, ".s_ready_back"}, s_ready[d], 1'b1);
    chk({tag, ".blk_cnt"}, 128'(blk_cnt[d]), 128'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      key_valid[d] = 1'b0; key[d] = '0; iv[d] = '0;
      s_valid[d] = 1'b0; s_data[d] = '0; s_last[d] = 1'b0; m_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chkb("rst.key_ready", key_ready[0], 1'b0);
    chkb("rst.s_ready", s_ready[0], 1'b0);
    chkb("rst.m_valid", m_valid[0], 1'b0);
    chk("rst.m_data", m_data[0], '0);
    chkb("rst.m_last", m_last[0], 1'b0);
    chk("rst.blk_cnt", 128'(blk_cnt[0]), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chkb("idle.key_ready", key_ready[0], 1'b1);
    chkb("idle.s_ready", s_ready[0], 1'b0);

    // AES-256 FIPS-197 vector with latency 14, then backpressure in OUT
    load_key(0, K256, FIPS_PT, "k256");
    run_block(0, '0, 1'b1, 14, 1'b1, E256, "aes256");
    s_valid[0] = 1'b1; s_data[0] = '1; key_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chkb("bp.m_valid", m_valid[0], 1'b1);
      chk("bp.m_data", m_data[0], E256);
      chkb("bp.m_last", m_last[0], 1'b1);
      chkb("bp.s_ready", s_ready[0], 1'b0);
      chkb("bp.key_ready", key_ready[0], 1'b0);
      chk("bp.blk_cnt", 128'(blk_cnt[0]), 128'd0);
    end
    s_valid[0] = 1'b0; key_valid[0] = 1'b0;
    release_out(0, 32'd1, "bp");

    // AES-128 FIPS-197 vector, then decrypt back to zero after a key-only reload
    load_key(1, K128, FIPS_PT, "k128");
    run_block(1, '0, 1'b1, 10, 1'b1, E128, "aes128");
    release_out(1, 32'd1, "aes128");
    load_key(1, K128, FIPS_PT, "k128_reload");
    run_block(1, E128, 1'b0, 10, 1'b1, '0, "aes128_inv");
    release_out(1, 32'd1, "aes128_inv");

    // Simultaneous key and block handshake: block uses the old key and counter
    load_key(1, K128, FIPS_PT, "k128_again");
    key[1] = KSP; iv[1] = CTR_SP; key_valid[1] = 1'b1;
    s_data[1] = '0; s_last[1] = 1'b0; s_valid[1] = 1'b1;
    chkb("both.s_ready", s_ready[1], 1'b1);
    chkb("both.key_ready", key_ready[1], 1'b1);
    @(negedge clk);
    key_valid[1] = 1'b0; s_valid[1] = 1'b0;
    wait_out(1, 10, 1'b1, E128, 1'b0, "both");
    chk("both.blk_cnt_zero", 128'(blk_cnt[1]), 128'd0);
    release_out(1, 32'd1, "both");
    run_block(1, PT1, 1'b1, 10, 1'b1, CT1, "newkey");
    release_out(1, 32'd2, "newkey");

    // CTR_BITS=8 wrap: ..fdffff -> ..fdff00, upper bits untouched
    load_key(1, KSP, IV_WRAP, "kwrap");
    run_block(1, '0, 1'b0, 10, 1'b0, '0, "wrap1");
    release_out(1, 32'd1, "wrap1");
    run_block(1, PT2, 1'b0, 10, 1'b1, CT2, "wrap2");
    release_out(1, 32'd2, "wrap2");

    // Reset sampled at round 7 drops the block; s_valid ignored until a new key
    s_data[0] = '0; s_last[0] = 1'b0; s_valid[0] = 1'b1;
    chkb("rst7.s_ready", s_ready[0], 1'b1);
    @(negedge clk);
    s_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chkb("rst7.m_valid", m_valid[0], 1'b0);
    chkb("rst7.s_ready", s_ready[0], 1'b0);
    chkb("rst7.key_ready_in_rst", key_ready[0], 1'b0);
    chk("rst7.m_data", m_data[0], '0);
    rst = 1'b0;
    s_valid[0] = 1'b1; s_data[0] = '1;
    @(negedge clk);
    chkb("rst7.key_ready", key_ready[0], 1'b1);
    chkb("rst7.s_ready_idle", s_ready[0], 1'b0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid[0] || s_ready[0]) seen = 1'b1;
    end
    chkb("rst7.s_ignored", seen, 1'b0);
    s_valid[0] = 1'b0;
    load_key(0, K256, FIPS_PT, "k256_after_rst");
    run_block(0, '0, 1'b0, 14, 1'b1, E256, "aes256_after_rst");
    release_out(0, 32'd1, "aes256_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
